// File: rtl/pvz_pkg.sv
// rtl/pvz_pkg.sv - shared lawn geometry, slot index width and pea position type
// Contents:
//   LANES, SLOTS, X_W, SCREEN_W : lawn geometry shared with the renderer
//   SLOT_IDX_W                  : width of a per-lane slot index
//   lane_pos_t                  : horizontal pixel position on a lane
//   lowest_set()                : index of the lowest set bit of an 8-bit vector
package pvz_pkg;

    localparam int LANES      = 5;
    localparam int SLOTS      = 5;
    localparam int X_W        = 10;
    localparam int SCREEN_W   = 800;
    localparam int SLOT_IDX_W = 3;

    typedef logic [X_W-1:0] lane_pos_t;

    // Returns 0 when no bit is set; callers qualify the result with |v.
    function automatic logic [SLOT_IDX_W-1:0] lowest_set(input logic [7:0] v);
        logic [SLOT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = SLOT_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pea_lane.sv
// rtl/pea_lane.sv - one lawn row: fire cadence counter and pea slot pool
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clear           : synchronous pool/counter clear (game not running)
//   move_tick       : game timebase strobe
//   plant_en        : a peashooter stands on this lane
//   plant_x         : muzzle x of the peashooter
//   hit_valid       : renderer reports a hit on this lane
//   hit_slot        : slot index of the hit
//   pea_x           : slot x positions, slot 0 in LSBs
//   pea_valid       : slot occupancy
//   spawned         : combinational, a pea is being spawned this cycle
//   drop            : registered pulse, a shot was due with the pool full
// Build option PEA_FIRE_ON_PLANT_EN: a freshly placed peashooter fires on
// the very next move tick instead of waiting a full fire period.
module pea_lane
    import pvz_pkg::*;
#(
    parameter int SLOTS       = pvz_pkg::SLOTS,
    parameter int SCREEN_W    = pvz_pkg::SCREEN_W,
    parameter int PEA_STEP    = 2,
    parameter int FIRE_PERIOD = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  move_tick,
    input  logic                  plant_en,
    input  lane_pos_t             plant_x,
    input  logic                  hit_valid,
    input  logic [SLOT_IDX_W-1:0] hit_slot,
    output logic [SLOTS*X_W-1:0]  pea_x,
    output logic [SLOTS-1:0]      pea_valid,
    output logic                  spawned,
    output logic                  drop
);

    localparam logic [9:0]   FIRE_LAST = 10'(FIRE_PERIOD - 1);
    localparam logic [X_W:0] STEP_EXT  = (X_W + 1)'(PEA_STEP);
    localparam logic [X_W:0] LAST_X    = (X_W + 1)'(SCREEN_W - 1);

    logic [9:0]       cnt_q, cnt_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    lane_pos_t        x_q [SLOTS];
    lane_pos_t        x_d [SLOTS];
    logic             drop_q, drop_d;

    logic                  shot_due;
    logic [7:0]            free_vec;
    logic                  any_free;
    logic [SLOT_IDX_W-1:0] spawn_idx;
    logic                  spawn_ok;
    logic                  hit_ok;
    logic [X_W:0]          sum;

`ifdef PEA_FIRE_ON_PLANT_EN
    logic plant_en_q, plant_en_d;
    assign plant_en_d = plant_en;
`endif

    // Fire cadence: counts move ticks while a peashooter is present.
    always_comb begin
        cnt_d    = cnt_q;
        shot_due = 1'b0;
        if (!plant_en) begin
            cnt_d = '0;
`ifdef PEA_FIRE_ON_PLANT_EN
        end else if (!plant_en_q) begin
            // Just planted: arm the counter so the next tick fires.
            cnt_d = FIRE_LAST;
`endif
        end else if (move_tick) begin
            if (cnt_q == FIRE_LAST) begin
                cnt_d    = '0;
                shot_due = 1'b1;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
        end
    end

    // Free slots are judged on the registered occupancy, so a slot freed
    // by a hit or by leaving the screen this cycle cannot be refilled
    // until the following cycle.
    always_comb begin
        free_vec             = '0;
        free_vec[SLOTS-1:0]  = ~valid_q;
        any_free             = |free_vec;
        spawn_idx            = lowest_set(free_vec);
        spawn_ok             = shot_due && any_free;
        drop_d               = shot_due && !any_free;
        hit_ok               = hit_valid && ({1'b0, hit_slot} < 4'(SLOTS));
    end

    // Per-slot update. The three branches are mutually exclusive on a
    // slot: hit and advance need an occupied slot, spawn an empty one,
    // so a new pea is never advanced in its spawn cycle.
    always_comb begin
        valid_d = valid_q;
        sum     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            x_d[i] = x_q[i];
            if (hit_ok && (hit_slot == SLOT_IDX_W'(i)) && valid_q[i]) begin
                valid_d[i] = 1'b0;
                x_d[i]     = '0;
            end else if (valid_q[i] && move_tick) begin
                sum = {1'b0, x_q[i]} + STEP_EXT;
                if (sum > LAST_X) begin
                    valid_d[i] = 1'b0;
                    x_d[i]     = '0;
                end else begin
                    x_d[i] = sum[X_W-1:0];
                end
            end else if (spawn_ok && (spawn_idx == SLOT_IDX_W'(i))) begin
                valid_d[i] = 1'b1;
                x_d[i]     = plant_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q   <= '0;
            valid_q <= '0;
            drop_q  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

`ifdef PEA_FIRE_ON_PLANT_EN
    // Tracks plant_en even while the game is stopped, so a clear does not
    // fake a planting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            plant_en_q <= 1'b0;
        end else begin
            plant_en_q <= plant_en_d;
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            pea_x[i*X_W +: X_W] = x_q[i];
        end
    end

    assign pea_valid = valid_q;
    assign drop      = drop_q;
    assign spawned   = spawn_ok && !clear;

endmodule

// File: rtl/pea_shot_engine.sv
// rtl/pea_shot_engine.sv - pea projectile pool for all lanes, feeds the renderer
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   move_tick    : game timebase strobe
//   game_run     : low clears every pool and fire counter
//   plant_en     : per-lane peashooter present
//   plant_x      : per-lane muzzle x, lane 0 in LSBs
//   hit_valid    : per-lane hit report from the renderer
//   hit_slot     : per-lane hit slot index
//   pea_x        : pea x, index lane*SLOTS+slot
//   pea_valid    : slot occupied, index lane*SLOTS+slot
//   spawn_drop   : per-lane pulse, shot due with a full pool
//   fired_count  : peas spawned since reset, saturating
// Build option PEA_FIRE_ON_PLANT_EN: first shot on the move tick right
// after a peashooter is placed.
module pea_shot_engine
    import pvz_pkg::*;
#(
    parameter int LANES       = pvz_pkg::LANES,
    parameter int SLOTS       = pvz_pkg::SLOTS,
    parameter int SCREEN_W    = pvz_pkg::SCREEN_W,
    parameter int PEA_STEP    = 2,
    parameter int FIRE_PERIOD = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         move_tick,
    input  logic                         game_run,
    input  logic [LANES-1:0]             plant_en,
    input  logic [LANES*X_W-1:0]         plant_x,
    input  logic [LANES-1:0]             hit_valid,
    input  logic [LANES*SLOT_IDX_W-1:0]  hit_slot,
    output logic [LANES*SLOTS*X_W-1:0]   pea_x,
    output logic [LANES*SLOTS-1:0]       pea_valid,
    output logic [LANES-1:0]             spawn_drop,
    output logic [15:0]                  fired_count
);

    logic             run_clear;
    logic [LANES-1:0] spawned;
    logic [7:0]       n_spawn;
    logic [16:0]      fired_sum;
    logic [15:0]      fired_q, fired_d;

    assign run_clear = !game_run;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pea_lane #(
            .SLOTS       (SLOTS),
            .SCREEN_W    (SCREEN_W),
            .PEA_STEP    (PEA_STEP),
            .FIRE_PERIOD (FIRE_PERIOD)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clear     (run_clear),
            .move_tick (move_tick),
            .plant_en  (plant_en[l]),
            .plant_x   (plant_x[l*X_W +: X_W]),
            .hit_valid (hit_valid[l]),
            .hit_slot  (hit_slot[l*SLOT_IDX_W +: SLOT_IDX_W]),
            .pea_x     (pea_x[l*SLOTS*X_W +: SLOTS*X_W]),
            .pea_valid (pea_valid[l*SLOTS +: SLOTS]),
            .spawned   (spawned[l]),
            .drop      (spawn_drop[l])
        );
    end

    // Several lanes may spawn together; add them all, clamp at all-ones.
    always_comb begin
        n_spawn = '0;
        for (int l = 0; l < LANES; l++) begin
            n_spawn = n_spawn + 8'(spawned[l]);
        end
        fired_sum = 17'(fired_q) + 17'(n_spawn);
        fired_d   = fired_q;
        if (game_run) begin
            fired_d = fired_sum[16] ? 16'hFFFF : fired_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fired_q <= '0;
        end else begin
            fired_q <= fired_d;
        end
    end

    assign fired_count = fired_q;

endmodule
